// File: rtl/a51_keystream.sv
// Purpose : A5/1 keystream core. It loads a 64-bit key and a 22-bit frame number, runs the mixing clocks, and then emits keystream bits.
// Latency : 1 cycle. A strobe sampled on edge n is reflected in KS/KS_VALID/DOUT after edge n. All outputs are registered.
// Backpr. : none. The sequencer strobes pace the core. With no strobe high, all state holds and KS_VALID is 0.
// Ports   : C / CLR_N (async active-low) ; STAGEONE/STAGETWO/STAGETHREE/OUTPUTSTAGE phase strobes
//           KEY[63:0], FRAME[21:0] ; KS, KS_VALID, SEQ_ERR (sticky)
// Config  : define A51_CIPHER_EN to add DIN/DOUT, where DOUT = DIN ^ keystream.
module a51_keystream (
    input  logic        C,
    input  logic        CLR_N,
    input  logic        STAGEONE,
    input  logic        STAGETWO,
    input  logic        STAGETHREE,
    input  logic        OUTPUTSTAGE,
    input  logic [63:0] KEY,
    input  logic [21:0] FRAME,
`ifdef A51_CIPHER_EN
    input  logic        DIN,
    output logic        DOUT,
`endif
    output logic        KS,
    output logic        KS_VALID,
    output logic        SEQ_ERR
);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_FRM, S_MIX, S_OUT} state_t;

    state_t      state, state_nxt, phase;
    logic [18:0] r1, r1_nxt, r1_clk, r1_maj;
    logic [21:0] r2, r2_nxt, r2_clk, r2_maj;
    logic [22:0] r3, r3_nxt, r3_clk, r3_maj;
    logic [6:0]  idx, idx_nxt, idx_inc, fidx;
    logic [31:0] frame_ext;
    logic        maj, entry, multi, kbit, fbit, ks_new;
    logic        ks_nxt, ksv_nxt, err_nxt, err_set;
`ifdef A51_CIPHER_EN
    logic        dout_nxt;
`endif

    always_comb begin
        // Strobe priority decode. The IDLE phase leaves everything untouched.
        if (STAGEONE)         phase = S_KEY;
        else if (STAGETWO)    phase = S_FRM;
        else if (STAGETHREE)  phase = S_MIX;
        else if (OUTPUTSTAGE) phase = S_OUT;
        else                  phase = S_IDLE;

        multi = (STAGEONE & STAGETWO) | (STAGEONE & STAGETHREE) | (STAGEONE & OUTPUTSTAGE) |
                (STAGETWO & STAGETHREE) | (STAGETWO & OUTPUTSTAGE) | (STAGETHREE & OUTPUTSTAGE);
        entry   = (phase != S_IDLE) && (phase != state);
        idx_inc = (idx == 7'd127) ? idx : idx + 7'd1;

        r1_clk = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18]};
        r2_clk = {r2[20:0], r2[20] ^ r2[21]};
        r3_clk = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22]};

        maj    = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        r1_maj = (r1[8]  == maj) ? r1_clk : r1;
        r2_maj = (r2[10] == maj) ? r2_clk : r2;
        r3_maj = (r3[10] == maj) ? r3_clk : r3;
        ks_new = r1_maj[18] ^ r2_maj[21] ^ r3_maj[22];

        // Indices beyond the key/frame width contribute nothing. Such
        // over-long phases are reported through the count checks instead.
        kbit      = KEY[idx[5:0]] & ~idx[6];
        frame_ext = {10'b0, FRAME};
        fidx      = entry ? 7'd0 : idx;
        fbit      = frame_ext[fidx[4:0]] & ~(|fidx[6:5]);

        state_nxt = (phase == S_IDLE) ? state : phase;
        r1_nxt    = r1;
        r2_nxt    = r2;
        r3_nxt    = r3;
        idx_nxt   = idx;
        ks_nxt    = KS;
        ksv_nxt   = 1'b0;
`ifdef A51_CIPHER_EN
        dout_nxt  = DOUT;
`endif
        err_set   = multi;

        case (phase)
            S_KEY: begin
                if (entry) begin
                    // Start from cleared registers. Clocking zeros yields zeros,
                    // so only key bit 0 remains.
                    r1_nxt  = {18'b0, KEY[0]};
                    r2_nxt  = {21'b0, KEY[0]};
                    r3_nxt  = {22'b0, KEY[0]};
                    idx_nxt = 7'd1;
                end else begin
                    r1_nxt  = r1_clk ^ {18'b0, kbit};
                    r2_nxt  = r2_clk ^ {21'b0, kbit};
                    r3_nxt  = r3_clk ^ {22'b0, kbit};
                    idx_nxt = idx_inc;
                end
            end
            S_FRM: begin
                r1_nxt  = r1_clk ^ {18'b0, fbit};
                r2_nxt  = r2_clk ^ {21'b0, fbit};
                r3_nxt  = r3_clk ^ {22'b0, fbit};
                idx_nxt = entry ? 7'd1 : idx_inc;
                if (entry && (state != S_KEY || idx != 7'd64)) err_set = 1'b1;
            end
            S_MIX: begin
                r1_nxt  = r1_maj;
                r2_nxt  = r2_maj;
                r3_nxt  = r3_maj;
                idx_nxt = entry ? 7'd1 : idx_inc;
                if (entry && (state != S_FRM || idx != 7'd22)) err_set = 1'b1;
            end
            S_OUT: begin
                r1_nxt  = r1_maj;
                r2_nxt  = r2_maj;
                r3_nxt  = r3_maj;
                idx_nxt = entry ? 7'd1 : idx_inc;
                ks_nxt  = ks_new;
                ksv_nxt = 1'b1;
`ifdef A51_CIPHER_EN
                dout_nxt = DIN ^ ks_new;
`endif
                if (entry && (state != S_MIX || idx != 7'd100)) err_set = 1'b1;
            end
            default: ;
        endcase

        // KEY entry clears the sticky error. A violation on the same edge still sets it.
        err_nxt = ((phase == S_KEY && entry) ? 1'b0 : SEQ_ERR) | err_set;
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state    <= S_IDLE;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            idx      <= '0;
            KS       <= 1'b0;
            KS_VALID <= 1'b0;
            SEQ_ERR  <= 1'b0;
`ifdef A51_CIPHER_EN
            DOUT     <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            r1       <= r1_nxt;
            r2       <= r2_nxt;
            r3       <= r3_nxt;
            idx      <= idx_nxt;
            KS       <= ks_nxt;
            KS_VALID <= ksv_nxt;
            SEQ_ERR  <= err_nxt;
`ifdef A51_CIPHER_EN
            DOUT     <= dout_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_a51_keystream.sv
// Purpose : scoreboard bench for a51_keystream against the published A5/1 reference stream.
// Latency : expected bits are queued at the stimulus edge and popped on the following negedge when KS_VALID is high.
// Backpr. : none. The bench drives the sequencer strobes directly.
`timescale 1ns/1ps
module tb_a51_keystream;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, so = 1'b0;
    logic [63:0] key = 64'hEFCDAB8967452312;
    logic [21:0] frame = 22'h134;
    logic        din = 1'b0;
    logic        ks, ks_valid, seq_err;
`ifdef A51_CIPHER_EN
    logic        dout;
`endif

    // Reference keystream for the known key/frame pair, MSB first, 114 bits plus 6 zero pad bits.
    logic [119:0] ks_ref = 120'h534EAA582FE8151AB6E1855A728C00;
    logic [7:0]   pat    = 8'hA5;

    typedef struct packed {
        logic care;
        logic ks;
        logic dout;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    a51_keystream dut (
        .C          (clk),
        .CLR_N      (clr_n),
        .STAGEONE   (s1),
        .STAGETWO   (s2),
        .STAGETHREE (s3),
        .OUTPUTSTAGE(so),
        .KEY        (key),
        .FRAME      (frame),
`ifdef A51_CIPHER_EN
        .DIN        (din),
        .DOUT       (dout),
`endif
        .KS         (ks),
        .KS_VALID   (ks_valid),
        .SEQ_ERR    (seq_err)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge's strobes, queue the expectation, and return 1 ns after the edge.
    task automatic step(input logic [3:0] strobes, input logic push, input exp_t e, input logic d);
        {s1, s2, s3, so} = strobes;
        din = d;
        if (push) sbq.push_back(e);
        @(posedge clk);
        #1;
        {s1, s2, s3, so} = 4'b0000;
    endtask

    // Reference output bit i, optionally with round-trip din so that dout returns the pattern.
    task automatic out_ref(input int n, input logic roundtrip);
        for (int i = 0; i < n; i++) begin
            logic b, p;
            exp_t e;
            b = ks_ref[119 - i];
            p = pat[7 - (i % 8)];
            e.care = 1'b1;
            e.ks   = b;
            e.dout = roundtrip ? p : (p ^ b);
            step(4'b0001, 1'b1, e, roundtrip ? (p ^ b) : p);
        end
    endtask

    task automatic run_phase(input logic [3:0] strobes, input int n);
        repeat (n) step(strobes, 1'b0, '0, 1'b0);
    endtask

    // Monitor: every valid output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ks_valid) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ks_valid: got valid with empty scoreboard at %0t", $time);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.care) begin
                    check("ks_bit", ks, mon_e.ks);
`ifdef A51_CIPHER_EN
                    check("dout_bit", dout, mon_e.dout);
`endif
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("reset_ks", ks, 1'b0);
        check("reset_ks_valid", ks_valid, 1'b0);
        check("reset_seq_err", seq_err, 1'b0);
        clr_n = 1'b1;

        // Known vector: 64 KEY / 22 FRM / 100 MIX / 114 OUT
        run_phase(4'b1000, 64);
        run_phase(4'b0100, 22);
        run_phase(4'b0010, 100);
        check("no_valid_before_out", ks_valid, 1'b0);
        out_ref(114, 1'b0);
        check("known_seq_err", seq_err, 1'b0);
        run_phase(4'b0000, 1);
        check("valid_drops_after_out", ks_valid, 1'b0);
        check("ks_holds_after_out", ks, ks_ref[6]);

        // Idle hold in mid-MIX, with round-trip din
        run_phase(4'b1000, 64);
        run_phase(4'b0100, 22);
        run_phase(4'b0010, 50);
        run_phase(4'b0000, 5);
        check("idle_no_valid", ks_valid, 1'b0);
        check("idle_seq_err", seq_err, 1'b0);
        run_phase(4'b0010, 50);
        out_ref(16, 1'b1);
        check("idle_resume_seq_err", seq_err, 1'b0);

        // Short key load
        run_phase(4'b1000, 63);
        run_phase(4'b0100, 1);
        check("short_key_err_set", seq_err, 1'b1);
        run_phase(4'b0100, 21);
        run_phase(4'b0010, 100);
        repeat (4) step(4'b0001, 1'b1, '0, 1'b0);
        check("short_key_err_sticky", seq_err, 1'b1);

        // Async reset mid-OUT, applied between edges
        step(4'b0001, 1'b1, '0, 1'b0);
        check("pre_reset_valid", ks_valid, 1'b1);
        clr_n = 1'b0;
        #1;
        check("async_rst_ks_valid", ks_valid, 1'b0);
        check("async_rst_ks", ks, 1'b0);
        check("async_rst_seq_err", seq_err, 1'b0);
        sbq.delete();
        clr_n = 1'b1;
        #1;
        // Registers are cleared, so the majority-clocked keystream is all zeros.
        repeat (3) begin
            exp_t z;
            z.care = 1'b1;
            z.ks   = 1'b0;
            z.dout = 1'b0;
            step(4'b0001, 1'b1, z, 1'b0);
            check("post_rst_valid", ks_valid, 1'b1);
        end
        check("post_rst_seq_err", seq_err, 1'b1);

        // Counter-driven sequence across a wrap (cnt 1..1023, 0, 1..)
        for (int t = 0; t < 1219; t++) begin
            int   cnt;
            exp_t e;
            logic [3:0] st;
            logic d;
            cnt = (t + 1) % 1024;
            e = '0;
            d = 1'b0;
            if (cnt == 0)        st = 4'b0000;
            else if (cnt <= 64)  st = 4'b1000;
            else if (cnt <= 86)  st = 4'b0100;
            else if (cnt <= 186) st = 4'b0010;
            else begin
                int k;
                st = 4'b0001;
                k = cnt - 187;
                d = pat[7 - (k % 8)];
                if (k < 114) begin
                    e.care = 1'b1;
                    e.ks   = ks_ref[119 - k];
                    e.dout = d ^ ks_ref[119 - k];
                end
            end
            step(st, st == 4'b0001, e, d);
            if (t == 0) check("key_entry_clears_err", seq_err, 1'b0);
        end
        check("wrap_seq_err", seq_err, 1'b0);

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
